float16_adder: RTL and testbench

- Registered IEEE-754 binary16 (half-precision) adder: sign[15], exponent[14:10] (bias 15), fraction[9:0].
- Adds two operands and produces the sum plus status flags (overflow, zero, NaN, precision loss).
- Sits as a single-stage arithmetic unit in the fixed/floating-point datapath.
- Combinational core feeds one output register stage.

---
 rtl/float16_adder.sv | 140 ++++++++++++++
 tb/tb_float16_adder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/float16_adder.sv
// Registered IEEE-754 binary16 adder with round-toward-zero and status flags.
// One combinational add/normalise path feeding a single output register stage.
module float16_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        nan,
  output logic        precisionLost,
  output logic        valid_out
);

  // Operand classification
  logic w_inf1, w_inf2, w_nan1, w_nan2;
  assign w_nan1 = (num1[14:10] == 5'h1F) && (num1[9:0] != 10'd0);
  assign w_nan2 = (num2[14:10] == 5'h1F) && (num2[9:0] != 10'd0);
  assign w_inf1 = (num1[14:10] == 5'h1F) && (num1[9:0] == 10'd0);
  assign w_inf2 = (num2[14:10] == 5'h1F) && (num2[9:0] == 10'd0);

  // Larger magnitude leads; ties keep num1 in front so x + (-x) takes num1's sign.
  logic        w_swap;
  logic [15:0] w_big, w_sml;
  logic [4:0]  w_big_exp, w_sml_exp, w_exp_diff;
  logic [10:0] w_big_sig, w_sml_sig;
  assign w_swap     = num2[14:0] > num1[14:0];
  assign w_big      = w_swap ? num2 : num1;
  assign w_sml      = w_swap ? num1 : num2;
  assign w_big_exp  = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
  assign w_sml_exp  = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
  assign w_big_sig  = {|w_big[14:10], w_big[9:0]};
  assign w_sml_sig  = {|w_sml[14:10], w_sml[9:0]};
  assign w_exp_diff = w_big_exp - w_sml_exp;

  // Extended significands: {sig[10:0], guard, round, sticky}
  logic [23:0] w_sml_shift;
  logic [13:0] w_big_ext, w_sml_ext;
  logic [14:0] w_sum;
  assign w_sml_shift = {w_sml_sig, 13'd0} >> w_exp_diff;
  assign w_big_ext   = {w_big_sig, 3'b000};
  assign w_sml_ext   = (w_exp_diff >= 5'd14) ? {13'd0, |w_sml_sig}
                                             : {w_sml_shift[23:11], |w_sml_shift[10:0]};
  // Sticky as an LSB keeps the truncated difference exact at guard/round resolution.
  assign w_sum = (w_big[15] == w_sml[15]) ? ({1'b0, w_big_ext} + {1'b0, w_sml_ext})
                                          : ({1'b0, w_big_ext} - {1'b0, w_sml_ext});

  logic [5:0]  w_lz, w_shamt, w_exp_m1, w_norm_exp;
  logic [13:0] w_norm;
  assign w_exp_m1 = {1'b0, w_big_exp} - 6'd1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_lz = 6'd14;
    for (int i = 0; i < 14; i++) begin
      if (w_sum[i]) w_lz = 6'(13 - i);
    end
  end

  always_comb begin
    w_shamt    = 6'd0;
    w_norm     = w_sum[13:0];
    w_norm_exp = {1'b0, w_big_exp};
    if (w_sum[14]) begin
      w_norm     = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_norm_exp = {1'b0, w_big_exp} + 6'd1;
    end else begin
      // Left shift stops at exponent 1; anything still unnormalised is subnormal.
      w_shamt    = (w_lz > w_exp_m1) ? w_exp_m1 : w_lz;
      w_norm     = w_sum[13:0] << w_shamt;
      w_norm_exp = {1'b0, w_big_exp} - w_shamt;
    end
  end

  logic        w_inexact;
  logic [4:0]  w_exp_field;
  assign w_inexact   = |w_norm[2:0];
  assign w_exp_field = w_norm[13] ? w_norm_exp[4:0] : 5'd0;

  logic [15:0] w_result;
  logic        w_ovf, w_zero, w_nan, w_pl;

  always_comb begin
    w_result = {w_big[15], w_exp_field, w_norm[12:3]};
    w_ovf    = 1'b0;
    w_zero   = 1'b0;
    w_nan    = 1'b0;
    w_pl     = w_inexact;
    if (w_nan1) begin
      w_result = num1;
      w_nan    = 1'b1;
      w_pl     = 1'b0;
    end else if (w_nan2) begin
      w_result = num2;
      w_nan    = 1'b1;
      w_pl     = 1'b0;
    end else if (w_inf1 && w_inf2 && (num1[15] != num2[15])) begin
      w_result = 16'h7E00;
      w_nan    = 1'b1;
      w_pl     = 1'b0;
    end else if (w_inf1) begin
      w_result = num1;
      w_ovf    = 1'b1;
      w_pl     = 1'b0;
    end else if (w_inf2) begin
      w_result = num2;
      w_ovf    = 1'b1;
      w_pl     = 1'b0;
    end else if (w_norm_exp >= 6'd31) begin
      w_result = {w_big[15], 5'h1F, 10'd0};
      w_ovf    = 1'b1;
    end else if (w_sum == 15'd0) begin
      w_result = {num1[15], 15'd0};
      w_zero   = 1'b1;
      w_pl     = 1'b0;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result        <= 16'h0000;
      overflow      <= 1'b0;
      zero          <= 1'b0;
      nan           <= 1'b0;
      precisionLost <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      result        <= w_result;
      overflow      <= w_ovf;
      zero          <= w_zero;
      nan           <= w_nan;
      precisionLost <= w_pl;
      valid_out     <= valid_in;
    end
  end

endmodule

// File: tb/tb_float16_adder.sv
// Directed-vector bench for float16_adder with hand-computed sums and flags.
// Flags are compared packed as {overflow, zero, nan, precisionLost}.
module tb_float16_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] num1, num2;
  logic [15:0] result;
  logic        overflow, zero, nan, precisionLost, valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  float16_adder dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .num1          (num1),
    .num2          (num2),
    .result        (result),
    .overflow      (overflow),
    .zero          (zero),
    .nan           (nan),
    .precisionLost (precisionLost),
    .valid_out     (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] flags();
    return {12'd0, overflow, zero, nan, precisionLost};
  endfunction

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic [3:0] exp_flags);
    @(negedge clk);
    num1 = a;
    num2 = b;
    @(posedge clk);
    #1;
    check({tag, " result"}, result, exp_res);
    check({tag, " flags"}, flags(), {12'd0, exp_flags});
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b1;
    num1     = 16'h3C00;
    num2     = 16'h3C00;
    #2;
    check("reset result", result, 16'h0000);
    check("reset flags", flags(), 16'h0000);
    check("reset valid", {15'd0, valid_out}, 16'h0000);
    @(posedge clk);
    #1;
    check("reset held result", result, 16'h0000);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;

    //                   tag            num1      num2      result    {ovf,zero,nan,pl}
    run_vec("same_exp",  16'h10A0, 16'h106C, 16'h1486, 4'b0000);
    run_vec("trunc_add", 16'h54A5, 16'h38CC, 16'h54AE, 4'b0001);
    run_vec("trunc_sub", 16'hC0B0, 16'h1CC0, 16'hC0AD, 4'b0001);
    run_vec("sticky14",  16'h29A8, 16'hE1F9, 16'hE1F8, 4'b0001);
    run_vec("cancel",    16'hF8AA, 16'h78AC, 16'h5400, 4'b0000);
    run_vec("subnorm",   16'h00B8, 16'h0080, 16'h0138, 4'b0000);
    run_vec("sub2norm",  16'h0200, 16'h0200, 16'h0400, 4'b0000);
    run_vec("neg_zero",  16'hE69D, 16'h669D, 16'h8000, 4'b0100);
    run_vec("pos_zero",  16'h3C00, 16'hBC00, 16'h0000, 4'b0100);
    run_vec("zero_zero", 16'h0000, 16'h0000, 16'h0000, 4'b0100);
    run_vec("nz_pz",     16'h8000, 16'h0000, 16'h8000, 4'b0100);
    run_vec("one_one",   16'h3C00, 16'h3C00, 16'h4000, 4'b0000);
    run_vec("nan2",      16'h44FF, 16'h7CFF, 16'h7CFF, 4'b0010);
    run_vec("nan_both",  16'h7E01, 16'h7D00, 16'h7E01, 4'b0010);
    run_vec("ovf_max",   16'h7BFF, 16'h7BFF, 16'h7C00, 4'b1000);
    run_vec("inf_num",   16'h7C00, 16'h4B83, 16'h7C00, 4'b1000);
    run_vec("ninf_num",  16'h3C00, 16'hFC00, 16'hFC00, 4'b1000);
    run_vec("inf_ninf",  16'h7C00, 16'hFC00, 16'h7E00, 4'b0010);

    // valid_in pulse shows up on valid_out one edge later, for exactly one cycle
    @(negedge clk);
    check("valid pre", {15'd0, valid_out}, 16'h0000);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check("valid pulse", {15'd0, valid_out}, 16'h0001);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("valid drop", {15'd0, valid_out}, 16'h0000);

    // asynchronous reset between edges
    @(negedge clk);
    valid_in = 1'b1;
    num1     = 16'h54A5;
    num2     = 16'h38CC;
    @(posedge clk);
    #1;
    check("pre_rst result", result, 16'h54AE);
    #2;
    rst = 1'b1;
    #1;
    check("async rst result", result, 16'h0000);
    check("async rst flags", flags(), 16'h0000);
    check("async rst valid", {15'd0, valid_out}, 16'h0000);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    run_vec("post_rst",  16'h10A0, 16'h106C, 16'h1486, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
